// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar echo controller and its helpers.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4,
        HOLDOFF   = 3'd5
    } sonar_state_e;

    localparam logic [1:0]  ALU_INC      = 2'b10;
    localparam logic [1:0]  ALU_DEC      = 2'b11;
    localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/mux4.sv
// 16-bit add/sub unit shared by the sensor blocks; purely combinational.
module mux4 (
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [1:0]  ctrl,
    output logic [15:0] result
);

    always_comb begin
        result = op_a;
        case (ctrl)
            2'b00:   result = op_a + op_b;
            2'b01:   result = op_a - op_b;
            2'b10:   result = op_a + 16'd1;
            default: result = op_a - 16'd1;
        endcase
    end

endmodule

// File: rtl/sonar_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus one-cycle rise/fall strobes.
module sonar_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign rise = sync_2 & ~prev;
    assign fall = ~sync_2 & prev;

endmodule

// File: rtl/sonar_echo_ctrl.sv
// One-channel sonar measurement controller: trigger, time echo width in us ticks,
// hand result out over valid/ready. Counting arithmetic goes through an external add/sub unit.
module sonar_echo_ctrl
    import sonar_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50,
    parameter int unsigned TRIG_CYCLES = 500,
    parameter int unsigned TIMEOUT_US  = 30000,
    parameter int unsigned HOLDOFF_US  = 60000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         echo,
    output logic         trig,
    output logic         busy,
    output logic [15:0]  dist_us,
    output logic         timeout,
    output logic         valid,
    input  logic         ready,
    output logic [15:0]  alu_opA,
    output logic [15:0]  alu_opB,
    output logic [1:0]   alu_ctrl,
    input  logic [15:0]  alu_result,
    output sonar_state_e dbg_state
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned TW = $clog2(TRIG_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST   = PW'(PRESCALE - 1);
    localparam logic [TW-1:0] TRIG_LAST    = TW'(TRIG_CYCLES - 1);
    localparam logic [15:0]   TIMEOUT_LIM  = 16'(TIMEOUT_US);
    localparam logic [15:0]   HOLDOFF_LOAD = 16'(HOLDOFF_US);

    sonar_state_e  state, state_d;
    logic [15:0]   count, count_d;
    logic [15:0]   dist_d;
    logic          timeout_d;
    logic [PW-1:0] presc;
    logic [TW-1:0] trig_cnt, trig_cnt_d;
    logic          presc_clr;
    logic          tick;
    logic          echo_rise;
    logic          echo_fall;

    sonar_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (echo),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            dist_us  <= '0;
            timeout  <= 1'b0;
            presc    <= '0;
            trig_cnt <= '0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            dist_us  <= dist_d;
            timeout  <= timeout_d;
            trig_cnt <= trig_cnt_d;
            if (presc_clr || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Limit compares look at count before this cycle's update, so count never passes the limit.
    always_comb begin
        state_d    = state;
        count_d    = count;
        dist_d     = dist_us;
        timeout_d  = timeout;
        trig_cnt_d = trig_cnt;
        presc_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d    = TRIG;
                    trig_cnt_d = '0;
                end
            end
            TRIG: begin
                trig_cnt_d = trig_cnt + 1'b1;
                if (trig_cnt == TRIG_LAST) begin
                    state_d   = WAIT_RISE;
                    count_d   = '0;
                    presc_clr = 1'b1;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d   = MEASURE;
                    count_d   = '0;
                    presc_clr = 1'b1;
                end else if (count >= TIMEOUT_LIM) begin
                    state_d   = DONE;
                    dist_d    = DIST_TIMEOUT;
                    timeout_d = 1'b1;
                end else if (tick) begin
                    count_d = alu_result;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_d   = DONE;
                    dist_d    = count;
                    timeout_d = 1'b0;
                end else if (count >= TIMEOUT_LIM) begin
                    state_d   = DONE;
                    dist_d    = DIST_TIMEOUT;
                    timeout_d = 1'b1;
                end else if (tick) begin
                    count_d = alu_result;
                end
            end
            DONE: begin
                if (ready) begin
                    state_d   = HOLDOFF;
                    count_d   = HOLDOFF_LOAD;
                    presc_clr = 1'b1;
                end
            end
            HOLDOFF: begin
                if (count == 16'd0) begin
                    state_d = IDLE;
                end else if (tick) begin
                    count_d = alu_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign trig      = (state == TRIG);
    assign busy      = (state != IDLE);
    assign valid     = (state == DONE);
    assign alu_opA   = count;
    assign alu_opB   = 16'd0;
    assign alu_ctrl  = (state == HOLDOFF) ? ALU_DEC : ALU_INC;
    assign dbg_state = state;

endmodule

// File: tb/tb_sonar_echo_ctrl.sv
// Directed bench for sonar_echo_ctrl with the mux4 add/sub unit wired in.
module tb_sonar_echo_ctrl;
    import sonar_pkg::*;

    localparam int PRESCALE    = 4;
    localparam int TRIG_CYCLES = 3;
    localparam int TIMEOUT_US  = 100;
    localparam int HOLDOFF_US  = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         echo;
    logic         ready;
    logic         trig;
    logic         busy;
    logic [15:0]  dist_us;
    logic         timeout;
    logic         valid;
    logic [15:0]  alu_opA;
    logic [15:0]  alu_opB;
    logic [1:0]   alu_ctrl;
    logic [15:0]  alu_result;
    sonar_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    sonar_echo_ctrl #(
        .PRESCALE    (PRESCALE),
        .TRIG_CYCLES (TRIG_CYCLES),
        .TIMEOUT_US  (TIMEOUT_US),
        .HOLDOFF_US  (HOLDOFF_US)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .echo       (echo),
        .trig       (trig),
        .busy       (busy),
        .dist_us    (dist_us),
        .timeout    (timeout),
        .valid      (valid),
        .ready      (ready),
        .alu_opA    (alu_opA),
        .alu_opB    (alu_opB),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .dbg_state  (dbg_state)
    );

    mux4 u_alu (
        .op_a   (alu_opA),
        .op_b   (alu_opB),
        .ctrl   (alu_ctrl),
        .result (alu_result)
    );

    // Driver tasks: all stimulus changes happen on the falling edge.
    task automatic fire_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure_trig(output int hi);
        hi = 0;
        while (trig === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        cyc = 0;
        while (valid !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = (valid === 1'b1);
    endtask

    task automatic wait_idle(input int budget, output int cyc, output bit ok);
        cyc = 0;
        while (busy !== 1'b0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_checks++;
        if (trig !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0 ||
            dist_us !== 16'd0 || alu_opA !== 16'd0 || alu_opB !== 16'd0 ||
            alu_ctrl !== ALU_INC || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs: trig=%b busy=%b valid=%b timeout=%b dist=%0d opA=%0d opB=%0d ctrl=%b state=%0d, required all zero, ctrl=10, IDLE",
                     trig, busy, valid, timeout, dist_us, alu_opA, alu_opB, alu_ctrl, dbg_state);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        int hi, cyc;
        bit ok;
        ready = 1'b1;
        exp_q.push_back(16'd37);
        fire_start();
        measure_trig(hi);
        n_checks++;
        if (hi !== TRIG_CYCLES) begin
            n_fail++;
            $display("FAIL normal_trig_width: got %0d clk, required %0d", hi, TRIG_CYCLES);
        end
        repeat (80) @(negedge clk);
        echo = 1'b1;
        repeat (148) @(negedge clk);
        echo = 1'b0;
        wait_valid(50, cyc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL normal_valid_wait: valid not seen within %0d clk", cyc);
        end
        begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if ($isunknown(dist_us) || dist_us + 16'd1 < e || dist_us > e + 16'd1 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL normal_result: dist=%0d timeout=%b, required %0d+/-1 timeout=0", dist_us, timeout, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_accept_first_cycle: valid=%b busy=%b, required valid=0 busy=1", valid, busy);
        end
        wait_idle(100, cyc, ok);
        n_checks++;
        if (!ok || cyc < 40 || cyc > 42) begin
            n_fail++;
            $display("FAIL normal_holdoff_len: busy for %0d clk after accept, required 40..42", cyc);
        end
    endtask

    task automatic test_no_echo();
        int hi, cyc;
        bit ok;
        ready = 1'b1;
        echo = 1'b0;
        exp_q.push_back(DIST_TIMEOUT);
        fire_start();
        measure_trig(hi);
        wait_valid(600, cyc, ok);
        n_checks++;
        if (!ok || cyc < 399 || cyc > 403) begin
            n_fail++;
            $display("FAIL no_echo_latency: valid after %0d clk (seen=%b), required 399..403", cyc, ok);
        end
        begin
            logic [15:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (dist_us !== e || timeout !== 1'b1) begin
                n_fail++;
                $display("FAIL no_echo_result: dist=%h timeout=%b, required %h timeout=1", dist_us, timeout, e);
            end
        end
        @(negedge clk);
        wait_idle(100, cyc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL no_echo_idle: busy=%b after %0d clk, required 0", busy, cyc);
        end
    endtask

    task automatic test_stuck_echo();
        int hi, cyc;
        bit ok;
        ready = 1'b1;
        fire_start();
        measure_trig(hi);
        repeat (8) @(negedge clk);
        echo = 1'b1;
        wait_valid(700, cyc, ok);
        n_checks++;
        if (!ok || cyc < 402 || cyc > 406 || dist_us !== DIST_TIMEOUT || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_echo_result: after %0d clk dist=%h timeout=%b, required 402..406 clk, FFFF, 1",
                     cyc, dist_us, timeout);
        end
        @(negedge clk);
        echo = 1'b0;
        wait_idle(100, cyc, ok);
        n_checks++;
        if (!ok || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_echo_idle: busy=%b timeout=%b, required busy=0 timeout held 1", busy, timeout);
        end
    endtask

    task automatic test_backpressure();
        int hi, cyc;
        bit ok, held_ok;
        logic [15:0] d0;
        ready = 1'b0;
        fire_start();
        measure_trig(hi);
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (60) @(negedge clk);
        echo = 1'b0;
        wait_valid(50, cyc, ok);
        n_checks++;
        if (!ok || $isunknown(dist_us) || dist_us < 16'd14 || dist_us > 16'd16 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: valid=%b dist=%0d timeout=%b, required valid=1 dist 14..16 timeout=0",
                     valid, dist_us, timeout);
        end
        d0 = dist_us;
        held_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = (i == 10);
            if (valid !== 1'b1 || dist_us !== d0 || timeout !== 1'b0 || trig !== 1'b0) held_ok = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (!held_ok) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b dist=%0d timeout=%b trig=%b, required held valid/dist and no trigger",
                     valid, dist_us, timeout, trig);
        end
        ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b busy=%b, required valid=0 busy=1", valid, busy);
        end
        wait_idle(100, cyc, ok);
        n_checks++;
        if (!ok || cyc < 40 || cyc > 42) begin
            n_fail++;
            $display("FAIL bp_holdoff_len: busy for %0d clk, required 40..42", cyc);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || trig !== 1'b0) held_ok = 1'b0;
        end
        n_checks++;
        if (!held_ok) begin
            n_fail++;
            $display("FAIL bp_start_dropped: busy=%b trig=%b, required stay idle", busy, trig);
        end
    endtask

    task automatic test_reset_mid_trig();
        int hi, cyc;
        bit ok;
        ready = 1'b1;
        fire_start();
        @(posedge clk);
        #2;
        n_checks++;
        if (trig !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_trig_before: trig=%b, required 1", trig);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (trig !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0 ||
            dist_us !== 16'd0 || alu_opA !== 16'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_async: trig=%b busy=%b valid=%b timeout=%b dist=%0d opA=%0d state=%0d, required all zero/IDLE",
                     trig, busy, valid, timeout, dist_us, alu_opA, dbg_state);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fire_start();
        measure_trig(hi);
        n_checks++;
        if (hi !== TRIG_CYCLES) begin
            n_fail++;
            $display("FAIL rst_retrig_width: got %0d clk, required %0d", hi, TRIG_CYCLES);
        end
        repeat (12) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        echo = 1'b0;
        wait_valid(50, cyc, ok);
        n_checks++;
        if (!ok || $isunknown(dist_us) || dist_us < 16'd24 || dist_us > 16'd26 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_clean_meas: valid=%b dist=%0d timeout=%b, required valid=1 dist 24..26 timeout=0",
                     valid, dist_us, timeout);
        end
        @(negedge clk);
        wait_idle(100, cyc, ok);
    endtask

    task automatic test_glitch_coincide();
        int hi, cyc;
        bit ok;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        echo  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        echo  = 1'b0;
        measure_trig(hi);
        n_checks++;
        if (hi !== TRIG_CYCLES) begin
            n_fail++;
            $display("FAIL glitch_trig_width: got %0d clk, required %0d", hi, TRIG_CYCLES);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (dbg_state !== WAIT_RISE) begin
            n_fail++;
            $display("FAIL glitch_ignored: state=%0d, required WAIT_RISE", dbg_state);
        end
        repeat (38) @(negedge clk);
        echo = 1'b1;
        repeat (401) @(negedge clk);
        echo = 1'b0;
        wait_valid(50, cyc, ok);
        n_checks++;
        if (!ok || dist_us !== 16'd100 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_at_limit: valid=%b dist=%0d timeout=%b, required valid=1 dist=100 timeout=0",
                     valid, dist_us, timeout);
        end
        @(negedge clk);
        wait_idle(100, cyc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL glitch_idle: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        echo  = 1'b0;
        ready = 1'b1;
        test_reset();
        test_normal();
        test_no_echo();
        test_stuck_echo();
        test_backpressure();
        test_reset_mid_trig();
        test_glitch_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
